// File: rtl/wb_gain_ctrl_pkg.sv
// wb_pkg: shared widths, constants and state encoding for the white-balance gain controller.
`default_nettype none

package wb_pkg;

  localparam int GAIN_W = 18;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 18'h100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CTRL   = 2'd1,
    ST_VIDEO  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_MAN_BK = 2'd1;
  localparam logic [1:0] ADDR_MAN_RK = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_AUTO_EN = 0;
  localparam int CTRL_FREEZE  = 1;
  localparam int CTRL_CLR_ERR = 2;

  localparam logic [3:0] PKT_VIDEO = 4'h0;

endpackage

`default_nettype wire

// File: rtl/wb_gain_ctrl_if.sv
// wb_gain_ctrl_if: monitored stream, register port, auto targets and committed gains.
`default_nettype none

interface wb_gain_ctrl_if;
  import wb_pkg::*;

  logic              st_valid;
  logic              st_ready;
  logic              st_sop;
  logic              st_eop;
  logic [7:0]        st_data;

  logic              cfg_wr;
  logic [1:0]        cfg_addr;
  logic [GAIN_W-1:0] cfg_wdata;
  logic [GAIN_W-1:0] cfg_rdata;

  logic [GAIN_W-1:0] auto_bk;
  logic [GAIN_W-1:0] auto_rk;
  logic              auto_valid;

  logic [GAIN_W-1:0] bk_gain;
  logic [GAIN_W-1:0] rk_gain;
  logic              gain_update;
  logic [15:0]       frame_cnt;
  logic              proto_err;

  modport master (
    output st_valid, st_ready, st_sop, st_eop, st_data,
    output cfg_wr, cfg_addr, cfg_wdata,
    input  cfg_rdata,
    output auto_bk, auto_rk, auto_valid,
    input  bk_gain, rk_gain, gain_update, frame_cnt, proto_err
  );

  modport slave (
    input  st_valid, st_ready, st_sop, st_eop, st_data,
    input  cfg_wr, cfg_addr, cfg_wdata,
    output cfg_rdata,
    input  auto_bk, auto_rk, auto_valid,
    output bk_gain, rk_gain, gain_update, frame_cnt, proto_err
  );

endinterface

`default_nettype wire

// File: rtl/wb_gain_step.sv
// wb_gain_step: one channel of first-order smoothing toward the target, then clamping.
`default_nettype none

module wb_gain_step
  import wb_pkg::*;
#(
  parameter logic [GAIN_W-1:0] GAIN_MIN     = 18'h010,
  parameter logic [GAIN_W-1:0] GAIN_MAX     = 18'h3FFFF,
  parameter int                SMOOTH_SHIFT = 0
) (
  input  logic [GAIN_W-1:0] cur,
  input  logic [GAIN_W-1:0] tgt,
  output logic [GAIN_W-1:0] gain_next
);

  localparam int DW = GAIN_W + 1;

  logic signed [DW-1:0] diff;
  logic signed [DW-1:0] step;
  logic signed [DW-1:0] sum;
  logic                 near;
  logic [GAIN_W-1:0]    smoothed;

  always_comb begin
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    step = diff >>> SMOOTH_SHIFT;
    sum  = $signed({1'b0, cur}) + step;
    // A one-LSB gap would never close under the shift, so snap to the target.
    near = (diff == '0) || (diff == '1) || (diff == DW'(1));
    smoothed = ((SMOOTH_SHIFT == 0) || near) ? tgt : sum[GAIN_W-1:0];

    if (smoothed < GAIN_MIN) begin
      gain_next = GAIN_MIN;
    end else if (smoothed > GAIN_MAX) begin
      gain_next = GAIN_MAX;
    end else begin
      gain_next = smoothed;
    end
  end

  // The sum always lies between cur and tgt, so its sign bit carries no information.
  logic unused_sign;
  assign unused_sign = sum[GAIN_W];

endmodule

`default_nettype wire

// File: rtl/wb_gain_ctrl.sv
// wb_gain_ctrl: tracks Avalon-ST packet framing and commits smoothed, clamped
// blue/red gains once per completed video packet.
`default_nettype none

module wb_gain_ctrl
  import wb_pkg::*;
#(
  parameter logic [GAIN_W-1:0] GAIN_MIN     = 18'h010,
  parameter logic [GAIN_W-1:0] GAIN_MAX     = 18'h3FFFF,
  parameter int                SMOOTH_SHIFT = 0
) (
  input  logic           clk,
  input  logic           rst,
  wb_gain_ctrl_if.slave  bus
);

  state_t            state;
  state_t            state_nxt;
  state_t            entry_state;

  logic              auto_en;
  logic              freeze;
  logic              pending;
  logic [GAIN_W-1:0] tgt_bk;
  logic [GAIN_W-1:0] tgt_rk;
  logic [GAIN_W-1:0] bk_gain;
  logic [GAIN_W-1:0] rk_gain;
  logic [GAIN_W-1:0] bk_next;
  logic [GAIN_W-1:0] rk_next;
  logic              gain_update;
  logic [15:0]       frame_cnt;
  logic              proto_err;

  logic              beat;
  logic              sop_beat;
  logic              eop_beat;
  logic              err_set;
  logic              frame_done;
  logic              do_commit;
  logic              load_bk;
  logic              load_rk;
  logic              ctrl_wr;

  assign beat     = bus.st_valid & bus.st_ready;
  assign sop_beat = beat & bus.st_sop;
  assign eop_beat = beat & bus.st_eop;

  logic unused_data;
  assign unused_data = ^bus.st_data[7:4];

  always_comb begin
    state_nxt  = state;
    err_set    = 1'b0;
    if (bus.st_data[3:0] == PKT_VIDEO) begin
      entry_state = bus.st_eop ? ST_COMMIT : ST_VIDEO;
    end else begin
      entry_state = bus.st_eop ? ST_IDLE : ST_CTRL;
    end

    case (state)
      ST_IDLE: begin
        if (sop_beat) state_nxt = entry_state;
      end
      ST_CTRL: begin
        if (sop_beat) begin
          err_set   = 1'b1;
          state_nxt = entry_state;
        end else if (eop_beat) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_VIDEO: begin
        if (sop_beat) begin
          err_set   = 1'b1;
          state_nxt = entry_state;
        end else if (eop_beat) begin
          state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_nxt = sop_beat ? entry_state : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // COMMIT is only ever entered on the closing beat of a video packet.
    frame_done = (state_nxt == ST_COMMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign ctrl_wr   = bus.cfg_wr && (bus.cfg_addr == ADDR_CTRL);
  assign load_bk   = (bus.cfg_wr && (bus.cfg_addr == ADDR_MAN_BK) && !auto_en) ||
                     (bus.auto_valid && auto_en);
  assign load_rk   = (bus.cfg_wr && (bus.cfg_addr == ADDR_MAN_RK) && !auto_en) ||
                     (bus.auto_valid && auto_en);
  assign do_commit = (state == ST_COMMIT) && pending && !freeze;

  wb_gain_step #(
    .GAIN_MIN     (GAIN_MIN),
    .GAIN_MAX     (GAIN_MAX),
    .SMOOTH_SHIFT (SMOOTH_SHIFT)
  ) u_step_bk (
    .cur       (bk_gain),
    .tgt       (tgt_bk),
    .gain_next (bk_next)
  );

  wb_gain_step #(
    .GAIN_MIN     (GAIN_MIN),
    .GAIN_MAX     (GAIN_MAX),
    .SMOOTH_SHIFT (SMOOTH_SHIFT)
  ) u_step_rk (
    .cur       (rk_gain),
    .tgt       (tgt_rk),
    .gain_next (rk_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_en     <= 1'b0;
      freeze      <= 1'b0;
      tgt_bk      <= GAIN_UNITY;
      tgt_rk      <= GAIN_UNITY;
      pending     <= 1'b0;
      bk_gain     <= GAIN_UNITY;
      rk_gain     <= GAIN_UNITY;
      gain_update <= 1'b0;
      frame_cnt   <= 16'd0;
      proto_err   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        auto_en <= bus.cfg_wdata[CTRL_AUTO_EN];
        freeze  <= bus.cfg_wdata[CTRL_FREEZE];
      end

      if (load_bk) tgt_bk <= bus.auto_valid && auto_en ? bus.auto_bk : bus.cfg_wdata;
      if (load_rk) tgt_rk <= bus.auto_valid && auto_en ? bus.auto_rk : bus.cfg_wdata;

      // A load landing in the commit cycle re-arms pending for the next frame.
      if (load_bk || load_rk) begin
        pending <= 1'b1;
      end else if (do_commit) begin
        pending <= 1'b0;
      end

      gain_update <= do_commit;
      if (do_commit) begin
        bk_gain <= bk_next;
        rk_gain <= rk_next;
      end

      if (frame_done) frame_cnt <= frame_cnt + 16'd1;

      if (err_set) begin
        proto_err <= 1'b1;
      end else if (ctrl_wr && bus.cfg_wdata[CTRL_CLR_ERR]) begin
        proto_err <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_addr)
      ADDR_CTRL:   bus.cfg_rdata = {{(GAIN_W-2){1'b0}}, freeze, auto_en};
      ADDR_MAN_BK: bus.cfg_rdata = tgt_bk;
      ADDR_MAN_RK: bus.cfg_rdata = tgt_rk;
      ADDR_STATUS: bus.cfg_rdata = GAIN_W'({proto_err, pending, frame_cnt});
      default:     bus.cfg_rdata = '0;
    endcase
  end

  assign bus.bk_gain     = bk_gain;
  assign bus.rk_gain     = rk_gain;
  assign bus.gain_update = gain_update;
  assign bus.frame_cnt   = frame_cnt;
  assign bus.proto_err   = proto_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_gain_ctrl.sv
// tb_wb_gain_ctrl: two instances (direct load and shift-2 smoothing) share one stimulus;
// expected gain commits are queued per instance and checked by a negedge monitor.
`default_nettype none

module tb_wb_gain_ctrl;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_gain_ctrl_if bus0 ();
  wb_gain_ctrl_if bus1 ();

  wb_gain_ctrl #(.GAIN_MIN(18'h010), .GAIN_MAX(18'h3FFFF), .SMOOTH_SHIFT(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  wb_gain_ctrl #(.GAIN_MIN(18'h010), .GAIN_MAX(18'h3FFFF), .SMOOTH_SHIFT(2))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus1.st_valid   = bus0.st_valid;
  assign bus1.st_ready   = bus0.st_ready;
  assign bus1.st_sop     = bus0.st_sop;
  assign bus1.st_eop     = bus0.st_eop;
  assign bus1.st_data    = bus0.st_data;
  assign bus1.cfg_wr     = bus0.cfg_wr;
  assign bus1.cfg_addr   = bus0.cfg_addr;
  assign bus1.cfg_wdata  = bus0.cfg_wdata;
  assign bus1.auto_bk    = bus0.auto_bk;
  assign bus1.auto_rk    = bus0.auto_rk;
  assign bus1.auto_valid = bus0.auto_valid;

  typedef struct {
    logic [17:0] bk;
    logic [17:0] rk;
    int          at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   eop_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_check(input int d, input logic [17:0] bk, input logic [17:0] rk);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      checks++;
      failures++;
      $display("FAIL upd%0d: unexpected gain_update at cycle %0d bk=0x%0h rk=0x%0h", d, cyc, bk, rk);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("upd%0d_bk", d), 32'(bk), 32'(e.bk));
      chk($sformatf("upd%0d_rk", d), 32'(rk), 32'(e.rk));
      chk($sformatf("upd%0d_cycle", d), cyc, e.at);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.gain_update) mon_check(0, bus0.bk_gain, bus0.rk_gain);
      if (bus1.gain_update) mon_check(1, bus1.bk_gain, bus1.rk_gain);
    end
  end

  task automatic tick_clear();
    @(negedge clk);
    bus0.st_valid   = 1'b0;
    bus0.st_sop     = 1'b0;
    bus0.st_eop     = 1'b0;
    bus0.st_data    = 8'h00;
    bus0.cfg_wr     = 1'b0;
    bus0.cfg_addr   = ADDR_CTRL;
    bus0.cfg_wdata  = '0;
    bus0.auto_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick_clear();
  endtask

  task automatic wr(input logic [1:0] a, input logic [17:0] d);
    tick_clear();
    bus0.cfg_wr    = 1'b1;
    bus0.cfg_addr  = a;
    bus0.cfg_wdata = d;
  endtask

  task automatic auto_ld(input logic [17:0] bk, input logic [17:0] rk);
    tick_clear();
    bus0.auto_bk    = bk;
    bus0.auto_rk    = rk;
    bus0.auto_valid = 1'b1;
  endtask

  task automatic beat(input logic sop, input logic eop, input logic [7:0] data);
    tick_clear();
    bus0.st_valid = 1'b1;
    bus0.st_sop   = sop;
    bus0.st_eop   = eop;
    bus0.st_data  = data;
    if (eop) eop_cyc = cyc;
  endtask

  task automatic video(input int n);
    beat(1'b1, 1'b0, 8'h00);
    repeat (n - 2) beat(1'b0, 1'b0, 8'h55);
    beat(1'b0, 1'b1, 8'h55);
  endtask

  task automatic push(input logic [17:0] b0, input logic [17:0] r0,
                      input logic [17:0] b1, input logic [17:0] r1);
    q0.push_back('{bk: b0, rk: r0, at: eop_cyc + 2});
    q1.push_back('{bk: b1, rk: r1, at: eop_cyc + 2});
  endtask

  task automatic rd(input string n, input logic [1:0] a, input logic [17:0] e0, input logic [17:0] e1);
    tick_clear();
    bus0.cfg_addr = a;
    #1;
    chk({n, "_0"}, 32'(bus0.cfg_rdata), 32'(e0));
    chk({n, "_1"}, 32'(bus1.cfg_rdata), 32'(e1));
  endtask

  task automatic obs(input string n, input logic [17:0] b0, input logic [17:0] r0,
                     input logic [17:0] b1, input logic [17:0] r1, input int f);
    tick_clear();
    #1;
    chk({n, "_bk0"}, 32'(bus0.bk_gain), 32'(b0));
    chk({n, "_rk0"}, 32'(bus0.rk_gain), 32'(r0));
    chk({n, "_bk1"}, 32'(bus1.bk_gain), 32'(b1));
    chk({n, "_rk1"}, 32'(bus1.rk_gain), 32'(r1));
    chk({n, "_fc0"}, 32'(bus0.frame_cnt), f);
    chk({n, "_fc1"}, 32'(bus1.frame_cnt), f);
  endtask

  task automatic do_reset();
    tick_clear();
    rst = 1'b1;
    tick_clear();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.st_ready = 1'b1;
    bus0.auto_bk  = '0;
    bus0.auto_rk  = '0;
    idle(2);
    rst = 1'b0;

    // Reset state
    obs("reset", 18'h100, 18'h100, 18'h100, 18'h100, 0);
    chk("reset_upd", 32'(bus0.gain_update), 0);
    chk("reset_err", 32'(bus0.proto_err), 0);
    rd("reset_status", ADDR_STATUS, 18'h0, 18'h0);
    rd("reset_ctrl", ADDR_CTRL, 18'h0, 18'h0);
    rd("reset_manbk", ADDR_MAN_BK, 18'h100, 18'h100);

    // Video packet with nothing pending: count only
    video(4);
    idle(4);
    obs("nopend", 18'h100, 18'h100, 18'h100, 18'h100, 1);

    // Manual blue target
    wr(ADDR_MAN_BK, 18'h180);
    video(4);
    push(18'h180, 18'h100, 18'h120, 18'h100);
    idle(4);
    obs("manbk", 18'h180, 18'h100, 18'h120, 18'h100, 2);
    rd("manbk_status", ADDR_STATUS, 18'h00002, 18'h00002);

    // Auto targets, smoothing over two frames
    do_reset();
    wr(ADDR_CTRL, 18'h1);
    auto_ld(18'h200, 18'h100);
    video(4);
    push(18'h200, 18'h100, 18'h140, 18'h100);
    idle(4);
    rd("auto1_status", ADDR_STATUS, 18'h00001, 18'h00001);
    auto_ld(18'h200, 18'h100);
    video(3);
    push(18'h200, 18'h100, 18'h170, 18'h100);
    idle(4);
    video(4);
    idle(4);
    obs("auto2", 18'h200, 18'h100, 18'h170, 18'h100, 3);

    // Control packet must not commit a pending target
    auto_ld(18'h300, 18'h080);
    beat(1'b1, 1'b0, 8'h0F);
    beat(1'b0, 1'b0, 8'h00);
    beat(1'b0, 1'b1, 8'h00);
    idle(4);
    rd("ctrlpkt_status", ADDR_STATUS, 18'h10003, 18'h10003);
    video(4);
    push(18'h300, 18'h080, 18'h1D4, 18'h0E0);
    idle(4);
    obs("ctrlpkt", 18'h300, 18'h080, 18'h1D4, 18'h0E0, 4);

    // Sop inside a video packet: error, restart, one commit at the real eop
    wr(ADDR_CTRL, 18'h0);
    wr(ADDR_MAN_BK, 18'h180);
    beat(1'b1, 1'b0, 8'h00);
    beat(1'b0, 1'b0, 8'h11);
    idle(3);
    rd("midvid_pend", ADDR_STATUS, 18'h10004, 18'h10004);
    beat(1'b1, 1'b0, 8'h00);
    beat(1'b0, 1'b0, 8'h22);
    beat(1'b0, 1'b1, 8'h33);
    push(18'h180, 18'h080, 18'h1BF, 18'h0C8);
    idle(4);
    chk("proto_err_set0", 32'(bus0.proto_err), 1);
    chk("proto_err_set1", 32'(bus1.proto_err), 1);
    rd("err_status", ADDR_STATUS, 18'h20005, 18'h20005);
    wr(ADDR_CTRL, 18'h4);
    idle(2);
    chk("proto_err_clr0", 32'(bus0.proto_err), 0);
    chk("proto_err_clr1", 32'(bus1.proto_err), 0);

    // Lower clamp on red
    wr(ADDR_MAN_RK, 18'h00005);
    video(4);
    push(18'h180, 18'h010, 18'h1AF, 18'h097);
    idle(4);
    obs("clamp", 18'h180, 18'h010, 18'h1AF, 18'h097, 6);

    // Freeze holds the pending target until a later frame
    wr(ADDR_CTRL, 18'h2);
    wr(ADDR_MAN_BK, 18'h220);
    video(4);
    idle(4);
    obs("frozen", 18'h180, 18'h010, 18'h1AF, 18'h097, 7);
    rd("frozen_status", ADDR_STATUS, 18'h10007, 18'h10007);
    wr(ADDR_CTRL, 18'h0);
    video(4);
    push(18'h220, 18'h010, 18'h1CB, 18'h072);
    idle(4);
    obs("thaw", 18'h220, 18'h010, 18'h1CB, 18'h072, 8);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_gain_ctrl.md
# wb_gain_ctrl

Frame-synchronous controller for the white-balance multiplier stage. It monitors the Avalon-ST video stream that enters the stage and holds the blue and red gain targets, supplied either by the host register port or by the auto-statistics block. It commits new gains only at the end of a video packet, with clamping and optional first-order smoothing. The gain multiplier always runs with a stable, frame-aligned pair of coefficients.

## Interface
- GAIN_W, 18: gain width, unsigned, 8 fractional bits (0x100 = 1.0)
- GAIN_MIN, 18'h010: lower clamp applied at commit
- GAIN_MAX, 18'h3FFFF: upper clamp applied at commit
- SMOOTH_SHIFT, 0: smoothing shift; 0 = direct load, else new = cur + ((tgt - cur) >>> SMOOTH_SHIFT)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- st_valid / st_ready  in  1 each  stream handshake, monitored only; beat = st_valid & st_ready
- st_sop / st_eop  in  1 each  packet framing
- st_data  in  8  stream data; on an sop beat, bits [3:0] give the packet type (0 = video)
- cfg_wr  in  1  register write strobe
- cfg_addr  in  2  register address: 0 CTRL, 1 MAN_BK, 2 MAN_RK, 3 STATUS (read-only)
- cfg_wdata  in  GAIN_W  write data
- cfg_rdata  out  GAIN_W  combinational read of cfg_addr
- auto_bk / auto_rk  in  GAIN_W each  auto targets
- auto_valid  in  1  one-cycle strobe qualifying auto_bk/auto_rk
- bk_gain / rk_gain  out  GAIN_W each  committed gains
- gain_update  out  1  one-cycle pulse, coincident with new gain values
- frame_cnt  out  16  count of completed video packets, wraps at 0xFFFF to 0
- proto_err  out  1  sticky framing error flag

## Operation
- Reset values: bk_gain = rk_gain = 0x100; gain_update = 0; frame_cnt = 0; proto_err = 0; CTRL = 0; MAN_BK = MAN_RK = 0x100; pending = 0; state IDLE.
- CTRL bits:
  - bit0 auto_en
  - bit1 freeze
  - bit2 (write 1) clears proto_err
- STATUS read: {proto_err, pending, frame_cnt}, zero-extended.
- Target capture:
  - A write to MAN_BK or MAN_RK while auto_en = 0 loads that target and sets pending.
  - auto_valid while auto_en = 1 loads both targets and sets pending.
  - Other sources are ignored in the current mode.
- State machine (IDLE, CTRL, VIDEO, COMMIT):
  - IDLE: an sop beat goes to VIDEO if st_data[3:0] = 0, else to CTRL. A non-sop beat leaves the state unchanged.
  - CTRL: an eop beat goes to IDLE.
  - VIDEO: an eop beat goes to COMMIT, and frame_cnt increments.
  - A beat with both sop and eop set is a one-beat packet: VIDEO type goes to COMMIT, other types go to IDLE.
  - Sop beat inside CTRL or VIDEO: set proto_err, abandon the packet with no commit, and re-enter per the new packet type.
  - COMMIT, one cycle, always exits: if pending and not freeze, both gains get clamp(smooth(cur, tgt)), gain_update is pulsed, and pending is cleared. A same-cycle sop beat is decoded as in IDLE.
- Arithmetic: the difference is computed in GAIN_W+1 signed bits with an arithmetic shift. Clamping is applied after smoothing. A target already within 1 LSB of the current value loads directly.
- Freeze: commits are skipped, but pending is retained and applied at the first commit after freeze clears.
- Simultaneous events: a target load or cfg write in the COMMIT cycle is not used by that commit. It sets pending for the next frame.

## Timing
- Eop beat of a video packet at cycle N: state = COMMIT in N+1; new gains and gain_update are visible in N+2.
- Outputs are registered; cfg_rdata is the only combinational output.
- Gains change only on gain_update cycles, never inside a video packet.
- st_ready is never driven; the block has zero effect on stream throughput.
- Reset mid-packet restores all reset values within one cycle; the rest of that packet is ignored until the next sop beat.

## Structure
- Package wb_pkg holds:
  - GAIN_W
  - GAIN_UNITY = 18'h100
  - state encoding
  - register address constants
  - packet type constant PKT_VIDEO = 4'h0
- Sub-module wb_gain_step: combinational smoothing and clamp for one channel, instantiated twice (bk and rk).

## Test plan
- Reset, then a 4-beat video packet with no writes -> gain_update stays 0; gains remain 0x100; frame_cnt = 1.
- auto_en = 0, write MAN_BK = 0x180, then a video packet -> gain_update two cycles after the eop beat; bk_gain = 0x180; rk_gain = 0x100.
- SMOOTH_SHIFT = 2, auto_en = 1, auto_bk = 0x200, then 2 frames -> bk_gain = 0x140 after frame 1 (pending cleared); auto_valid again before frame 2 -> 0x170.
- Control packet (sop data 0xF) followed by eop, with pending set -> no commit; the next video eop commits.
- Sop beat mid-VIDEO -> proto_err = 1, no commit for the abandoned packet; CTRL bit2 write clears the flag.
- Write MAN_RK = 0x00005, then a frame -> rk_gain = 0x010 (clamped); freeze = 1 with a new write -> no update until freeze is cleared and the next frame ends.
